mc_control_fsm: RTL and testbench

MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

---
 rtl/mc_control_fsm.sv | 197 +++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle CPU control FSM. Latency is jmp 2, beq 3, alu/sw 4, lw 5 cycles plus memory wait states.
// With MC_CTRL_WAIT_EN defined, FETCH/MEM stall on mem_ready and time out to bus_err; otherwise memory is always ready.
module mc_control_fsm #(
  parameter int OPCODE_W = 3,
  parameter int TIMEOUT  = 15
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                ir_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                reg_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                alu_src,
  output logic [1:0]          pc_src,
  output logic                illegal,
  output logic                bus_err,
  output logic [2:0]          state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_SLI  = 3'b010;
  localparam logic [2:0] OP_ROT  = 3'b011;
  localparam logic [2:0] OP_BEQ  = 3'b100;
  localparam logic [2:0] OP_SW   = 3'b101;
  localparam logic [2:0] OP_LW   = 3'b110;
  localparam logic [2:0] OP_JMP  = 3'b111;

  if (OPCODE_W < 3 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_check
    $error("mc_control_fsm: OPCODE_W must be >= 3 and TIMEOUT within 1..255");
  end

  state_t     state_q, state_d;
  logic [2:0] op_q;
  logic       illegal_q;
  logic       set_illegal;
  logic       hi_nz;
  logic       ready_eff;
  logic       timeout_hit;

  // Any opcode bit above the 3-bit ISA field makes the instruction illegal.
  assign hi_nz = (opcode >> 3) != '0;

`ifdef MC_CTRL_WAIT_EN
  logic [7:0] wait_q;
  logic       bus_err_q;
  logic       in_wait;

  assign in_wait     = (state_q == S_FETCH) || (state_q == S_MEM);
  assign ready_eff   = mem_ready;
  // A ready on the final allowed cycle completes the access instead of faulting.
  assign timeout_hit = in_wait && !mem_ready && (wait_q == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_q    <= 8'd0;
      bus_err_q <= 1'b0;
    end else begin
      wait_q <= (in_wait && !mem_ready) ? wait_q + 8'd1 : 8'd0;
      if (timeout_hit) begin
        bus_err_q <= 1'b1;
      end
    end
  end

  assign bus_err = bus_err_q;
`else
  assign ready_eff   = mem_ready | 1'b1;
  assign timeout_hit = 1'b0;
  assign bus_err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_FETCH;
      op_q      <= 3'b000;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        op_q <= opcode[2:0];
      end
      if (set_illegal) begin
        illegal_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    set_illegal = 1'b0;
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src     = 1'b0;
    pc_src      = 2'b00;

    case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        if (ready_eff) begin
          // Reset holds the state at FETCH; keep the fetch strobes quiet until it releases.
          ir_write = reset_n;
          pc_write = reset_n;
          state_d  = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_HALT;
        end
      end

      S_DECODE: begin
        if (hi_nz) begin
          set_illegal = 1'b1;
          state_d     = S_HALT;
        end else if (opcode[2:0] == OP_JMP) begin
          pc_write = 1'b1;
          pc_src   = 2'b10;
          state_d  = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        case (op_q)
          OP_ADD: begin
            alu_src = 1'b0;
            state_d = S_WB;
          end
          OP_ADDI, OP_SLI, OP_ROT: begin
            alu_src = 1'b1;
            state_d = S_WB;
          end
          OP_BEQ: begin
            if (zero) begin
              pc_write = 1'b1;
              pc_src   = 2'b01;
            end
            state_d = S_FETCH;
          end
          OP_SW, OP_LW: begin
            alu_src = 1'b1;
            state_d = S_MEM;
          end
          default: state_d = S_FETCH;
        endcase
      end

      S_MEM: begin
        if (op_q == OP_LW) begin
          mem_read = 1'b1;
        end else begin
          mem_write = 1'b1;
        end
        if (ready_eff) begin
          state_d = (op_q == OP_LW) ? S_WB : S_FETCH;
        end else if (timeout_hit) begin
          state_d = S_HALT;
        end
      end

      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (op_q != OP_ADD);
        mem_to_reg = (op_q == OP_LW);
        state_d    = S_FETCH;
      end

      S_HALT: state_d = S_HALT;

      default: state_d = S_HALT;
    endcase
  end

  assign illegal = illegal_q;
  assign state   = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Testbench for mc_control_fsm: each instruction is expanded into a list of phases (with memory waits) and
// every cycle's outputs are compared to the values implied by the current phase, opcode, zero and mem_ready.
module tb_mc_control_fsm;

  localparam int TO = 15;
  localparam int PF = 0, PD = 1, PE = 2, PM = 3, PW = 4, PH = 5;
  localparam logic [14:0] RST_VEC = 15'h0200;

`ifdef MC_CTRL_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  logic       clk;
  logic       reset_n;
  logic [3:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, ir_write, mem_read, mem_write, reg_write;
  logic       reg_dst, mem_to_reg, alu_src;
  logic [1:0] pc_src;
  logic       illegal, bus_err;
  logic [2:0] state;
  logic [14:0] obs_vec;

  int n_cmp = 0;
  int n_bad = 0;
  bit m_ill;
  bit m_berr;
  int path[$];

  mc_control_fsm #(.OPCODE_W(4), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src(alu_src),
    .pc_src(pc_src), .illegal(illegal), .bus_err(bus_err), .state(state)
  );

  assign obs_vec = {state, pc_write, ir_write, mem_read, mem_write, reg_write,
                    reg_dst, mem_to_reg, alu_src, pc_src, illegal, bus_err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs expected in one cycle of a given phase.
  function automatic logic [14:0] model_out(input int ph, input logic [3:0] op, input logic z,
                                            input logic r, input logic ill, input logic be);
    logic pcw, irw, mrd, mwr, rgw, rdst, m2r, asrc;
    logic [1:0] psrc;
    {pcw, irw, mrd, mwr, rgw, rdst, m2r, asrc} = 8'h00;
    psrc = 2'b00;
    case (ph)
      PF: begin mrd = 1'b1; if (r) begin irw = 1'b1; pcw = 1'b1; end end
      PD: if (op == 4'd7) begin pcw = 1'b1; psrc = 2'b10; end
      PE: begin
        asrc = !(op == 4'd0 || op == 4'd4);
        if (op == 4'd4 && z) begin pcw = 1'b1; psrc = 2'b01; end
      end
      PM: if (op == 4'd6) mrd = 1'b1; else mwr = 1'b1;
      PW: begin rgw = 1'b1; rdst = (op != 4'd0); m2r = (op == 4'd6); end
      default: ;
    endcase
    return {3'(ph), pcw, irw, mrd, mwr, rgw, rdst, m2r, asrc, psrc, ill, be};
  endfunction

  task automatic set_route(input logic [3:0] op);
    path.delete();
    path.push_back(PF);
    path.push_back(PD);
    if (op > 4'd7) path.push_back(PH);
    else if (op != 4'd7) begin
      path.push_back(PE);
      if (op == 4'd5 || op == 4'd6) path.push_back(PM);
      if (op != 4'd4 && op != 4'd5) path.push_back(PW);
    end
  endtask

  // Runs one instruction from FETCH; nf/nm = mem_ready-low cycles presented in FETCH/MEM.
  task automatic exec_instr(input logic [3:0] op, input logic z, input int nf, input int nm,
                            output bit halted);
    int ph, fl, ml, hc, guard, m_wait;
    logic r, reff;
    logic [14:0] exp;
    set_route(op);
    halted = 1'b0; fl = 0; ml = 0; hc = 0; guard = 0; m_wait = 0;
    while (path.size() > 0) begin
      ph = path[0];
      if (ph == PF) r = (fl < nf) ? 1'b0 : 1'b1;
      else if (ph == PM) r = (ml < nm) ? 1'b0 : 1'b1;
      else r = 1'($urandom);
      reff = WAIT_EN ? r : 1'b1;
      opcode = (ph == PD) ? op : 4'($urandom);
      zero = (ph == PE) ? z : 1'($urandom);
      mem_ready = r;
      #2;
      exp = model_out(ph, op, z, reff, m_ill, m_berr);
      n_cmp++;
      if (obs_vec !== exp) begin
        n_bad++;
        $display("FAIL step op=%0h phase=%0d: got %b want %b", op, ph, obs_vec, exp);
      end
      @(posedge clk); #1;
      guard++;
      if (ph == PH) begin
        halted = 1'b1;
        hc++;
        if (hc == 3) path.delete();
      end else if ((ph == PF || ph == PM) && !reff) begin
        if (ph == PF) fl++; else ml++;
        m_wait++;
        if (m_wait == TO) begin
          m_berr = 1'b1;
          path.delete();
          path.push_back(PH);
        end
      end else begin
        m_wait = 0;
        if (ph == PD && op > 4'd7) m_ill = 1'b1;
        void'(path.pop_front());
      end
      if (guard > 600) begin
        n_cmp++; n_bad++;
        $display("FAIL step_budget op=%0h: got %0d cycles want <=600", op, guard);
        path.delete();
      end
    end
  endtask

  task automatic do_reset();
    mem_ready = 1'b1;
    reset_n = 1'b0;
    #2;
    n_cmp++;
    if (obs_vec !== RST_VEC) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b want %b", obs_vec, RST_VEC);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    m_ill = 1'b0;
    m_berr = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; opcode = 4'd5; zero = 1'b1; mem_ready = 1'b1;
    m_ill = 1'b0; m_berr = 1'b0;
    #3;
    n_cmp++;
    if (obs_vec !== RST_VEC) begin
      n_bad++;
      $display("FAIL reset_initial: got %b want %b", obs_vec, RST_VEC);
    end
    repeat (2) @(posedge clk);
    #3;
    n_cmp++;
    if (obs_vec !== RST_VEC) begin
      n_bad++;
      $display("FAIL reset_held_clocks: got %b want %b", obs_vec, RST_VEC);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_alu_ops();
    bit h;
    for (int op = 0; op < 4; op++) begin
      exec_instr(4'(op), 1'b0, 0, 0, h);
      n_cmp++;
      if (h !== 1'b0) begin n_bad++; $display("FAIL alu_halt op=%0d: got %0d want 0", op, h); end
    end
  endtask

  task automatic test_branch_jump();
    bit h;
    exec_instr(4'd4, 1'b0, 0, 0, h);
    exec_instr(4'd4, 1'b1, 0, 0, h);
    exec_instr(4'd7, 1'b0, 0, 0, h);
    exec_instr(4'd6, 1'b0, 0, 3, h);
    exec_instr(4'd5, 1'b0, 2, 2, h);
  endtask

  task automatic test_latency();
    logic [3:0] ops [10];
    logic       zs  [10];
    int         nms [10];
    int         lat [10];
    int cyc, mlow;
    ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd4, 4'd5, 4'd6, 4'd7, 4'd6};
    zs  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    nms = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 3};
    lat = '{4, 4, 4, 4, 3, 3, 4, 5, 2, 5};
    if (WAIT_EN) lat[9] = 8;
    for (int i = 0; i < 10; i++) begin
      cyc = 0; mlow = 0;
      while (cyc < 40) begin
        if (cyc > 0 && state == 3'd0) break;
        opcode = ops[i]; zero = zs[i];
        mem_ready = (state == 3'd3 && mlow < nms[i]) ? 1'b0 : 1'b1;
        @(posedge clk); #1;
        if (!mem_ready) mlow++;
        cyc++;
      end
      n_cmp++;
      if (cyc !== lat[i]) begin
        n_bad++;
        $display("FAIL latency op=%0d zero=%0d: got %0d cycles want %0d", ops[i], zs[i], cyc, lat[i]);
      end
    end
  endtask

  task automatic test_illegal();
    bit h;
    exec_instr(4'b1000, 1'b0, 0, 0, h);
    n_cmp++;
    if (h !== 1'b1) begin n_bad++; $display("FAIL illegal_halt_1000: got %0d want 1", h); end
    do_reset();
    exec_instr(4'b1111, 1'b1, 0, 0, h);
    n_cmp++;
    if (h !== 1'b1) begin n_bad++; $display("FAIL illegal_halt_1111: got %0d want 1", h); end
    do_reset();
  endtask

  task automatic test_timeout();
    bit h;
    exec_instr(4'd0, 1'b0, TO, 0, h);
    n_cmp++;
    if (h !== WAIT_EN) begin n_bad++; $display("FAIL timeout_fetch: halted %0d want %0d", h, WAIT_EN); end
    if (h) do_reset();
    exec_instr(4'd6, 1'b0, TO - 1, TO - 1, h);
    n_cmp++;
    if (h !== 1'b0) begin n_bad++; $display("FAIL ready_at_limit: halted %0d want 0", h); end
    exec_instr(4'd5, 1'b0, 0, TO, h);
    n_cmp++;
    if (h !== WAIT_EN) begin n_bad++; $display("FAIL timeout_mem: halted %0d want %0d", h, WAIT_EN); end
    if (h) do_reset();
  endtask

  task automatic test_reset_mid_op();
    logic [3:0] ops [2];
    ops = '{4'd0, 4'd5};
    for (int i = 0; i < 2; i++) begin
      opcode = ops[i]; zero = 1'b0;
      repeat (3) begin mem_ready = 1'b1; @(posedge clk); #1; end
      mem_ready = 1'b0;
      #1;
      n_cmp++;
      if ({state, reg_write, mem_write} !== ((i == 0) ? 5'b100_1_0 : 5'b011_0_1)) begin
        n_bad++;
        $display("FAIL pre_reset_strobe op=%0d: got %b", ops[i], {state, reg_write, mem_write});
      end
      reset_n = 1'b0;
      #1;
      n_cmp++;
      if (obs_vec !== RST_VEC) begin
        n_bad++;
        $display("FAIL async_reset_drop op=%0d: got %b want %b", ops[i], obs_vec, RST_VEC);
      end
      @(posedge clk); #1;
      reset_n = 1'b1;
      m_ill = 1'b0; m_berr = 1'b0;
    end
  endtask

  task automatic test_random_stream();
    bit h;
    logic [3:0] op;
    int nf, nm, sel;
    for (int k = 0; k < 120; k++) begin
      op = ($urandom_range(0, 7) == 0) ? 4'(8 + $urandom_range(0, 7)) : 4'($urandom_range(0, 7));
      sel = $urandom_range(0, 19);
      nf = (sel == 0) ? TO : ((sel < 10) ? 0 : $urandom_range(0, 3));
      sel = $urandom_range(0, 19);
      nm = (sel == 0) ? TO : ((sel < 10) ? 0 : $urandom_range(0, 3));
      exec_instr(op, 1'($urandom), nf, nm, h);
      if (h) do_reset();
    end
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_branch_jump();
    test_latency();
    test_illegal();
    test_timeout();
    test_reset_mid_op();
    test_random_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
